// File: rtl/radix5_out_reorder_if.sv
// Handshake and data bundle for the radix-5 output reorder buffer.
// slave: the reorder buffer; master: its surroundings (upstream butterfly + downstream sink).
// Optional out_last marker exists only when R5_FRAME_MARKERS_EN is defined.
interface radix5_out_reorder_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_re, a_img;
  logic [W-1:0] b_re, b_img;
  logic [W-1:0] c_re, c_img;
  logic [W-1:0] d_re, d_img;
  logic [W-1:0] e_re, e_img;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_img;
`ifdef R5_FRAME_MARKERS_EN
  logic         out_last;

  modport master (
    output in_valid, a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img,
    output out_ready,
    input  in_ready, out_valid, out_re, out_img, out_last
  );

  modport slave (
    input  in_valid, a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img,
    input  out_ready,
    output in_ready, out_valid, out_re, out_img, out_last
  );
`else
  modport master (
    output in_valid, a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img,
    output out_ready,
    input  in_ready, out_valid, out_re, out_img
  );

  modport slave (
    input  in_valid, a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img,
    input  out_ready,
    output in_ready, out_valid, out_re, out_img
  );
`endif
endinterface

// File: rtl/radix5_out_reorder.sv
// Ping-pong reorder buffer: 5 lanes x 5 beats in digit-reversed order -> 25 bins in natural
// order on a single valid/ready stream. Define R5_FRAME_MARKERS_EN to get out_last on bin 24.
module radix5_out_reorder #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 25
) (
  input logic               clk,
  input logic               rst,
  radix5_out_reorder_if.slave bus
);
  localparam int unsigned R = 5;

  logic [2*W-1:0] mem_q [2][N];
  logic [2*W-1:0] lane_w [R];
  logic [2*W-1:0] rd_word;

  logic [1:0]   full_q, full_d;
  logic         wbank_q, wbank_d;
  logic [2:0]   g_q, g_d;
  // Load side runs one bin ahead of the release side so frames can abut without a bubble.
  logic         lbank_q, lbank_d;
  logic [4:0]   ln_q, ln_d;
  logic         rbank_q, rbank_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_re_q, out_re_d;
  logic [W-1:0] out_img_q, out_img_d;
  logic         last_q, last_d;

  logic in_fire, out_adv, out_load, out_release;

  assign lane_w[0] = {bus.a_img, bus.a_re};
  assign lane_w[1] = {bus.b_img, bus.b_re};
  assign lane_w[2] = {bus.c_img, bus.c_re};
  assign lane_w[3] = {bus.d_img, bus.d_re};
  assign lane_w[4] = {bus.e_img, bus.e_re};

  assign bus.in_ready = !rst && !full_q[wbank_q];
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_adv      = !out_valid_q || bus.out_ready;
  assign out_load     = out_adv && full_q[lbank_q];
  // Bank is freed only when its bin 24 actually leaves the output register.
  assign out_release  = out_valid_q && bus.out_ready && last_q;
  assign rd_word      = mem_q[lbank_q][ln_q];

  // Bank storage: lane k of beat g lands at entry 5*k + g, which is natural bin order.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < R; k++) begin
        mem_q[wbank_q][5'(R * k) + 5'(g_q)] <= lane_w[k];
      end
    end
  end

  // Next-state for write/read pointers, full flags and the output register.
  always_comb begin
    full_d      = full_q;
    wbank_d     = wbank_q;
    g_d         = g_q;
    rbank_d     = rbank_q;
    lbank_d     = lbank_q;
    ln_d        = ln_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_img_d   = out_img_q;
    last_d      = last_q;

    if (in_fire) begin
      if (g_q == 3'(R - 1)) begin
        g_d              = '0;
        full_d[wbank_q]  = 1'b1;
        wbank_d          = ~wbank_q;
      end else begin
        g_d = g_q + 3'd1;
      end
    end

    if (out_release) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end

    if (out_adv) begin
      out_valid_d = out_load;
      if (out_load) begin
        out_re_d  = rd_word[W-1:0];
        out_img_d = rd_word[2*W-1:W];
        last_d    = (ln_q == 5'(N - 1));
        if (ln_q == 5'(N - 1)) begin
          ln_d    = '0;
          lbank_d = ~lbank_q;
        end else begin
          ln_d = ln_q + 5'd1;
        end
      end
    end
  end

  // State registers with synchronous reset; bank contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      wbank_q     <= 1'b0;
      g_q         <= '0;
      rbank_q     <= 1'b0;
      lbank_q     <= 1'b0;
      ln_q        <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_img_q   <= '0;
      last_q      <= 1'b0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      g_q         <= g_d;
      rbank_q     <= rbank_d;
      lbank_q     <= lbank_d;
      ln_q        <= ln_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_img_q   <= out_img_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_img   = out_img_q;
`ifdef R5_FRAME_MARKERS_EN
  assign bus.out_last  = last_q;
`endif

endmodule
